mem_align_bridge: RTL and testbench

//  Sits between the multicycle rv32i control/datapath memory port and the physical memory port.
//  - Accepts the CPU's level-held read/write request; it stays asserted until mem_resp.
//  - Aligns byte-enables and write data to the word lane given by address[1:0].
//  - Issues a word-aligned physical access and waits for pmem_resp.
//  - Returns a one-cycle mem_resp with the raw aligned word.
//  - A timeout counter guarantees forward progress if physical memory never responds.

---
 rtl/mem_align_bridge_pkg.sv | 22 ++
 rtl/mem_align_bridge_byte_lane_align.sv | 23 ++
 rtl/mem_align_bridge.sv | 198 +++++++++++++++++++
 tb/tb_mem_align_bridge.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_align_bridge_pkg.sv
// Shared types and constants for the CPU-to-physical memory alignment bridge.
package mem_align_bridge_pkg;

  // Byte write mask, one bit per byte lane of a 32-bit word.
  typedef logic [3:0] rv32i_mem_wmask;

  // Bridge sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mem_bridge_state_t;

  // Read word returned to the CPU when a physical access is abandoned.
  localparam logic [31:0] MEM_ABORT_DATA = 32'hDEADBEEF;

  // Bit shift that moves a lane-0 byte into byte lane 'off'.
  function automatic logic [4:0] lane_shift(input logic [1:0] off);
    return {off, 3'b000};
  endfunction

endpackage

// File: rtl/mem_align_bridge_byte_lane_align.sv
// Combinational byte-lane steering: moves a lane-0 relative mask and write
// word up to the lane selected by the low address bits, flagging any mask
// bit pushed past lane 3.
module byte_lane_align
  import mem_align_bridge_pkg::*;
(
  input  rv32i_mem_wmask i_mask,
  input  logic [31:0]    i_wdata,
  input  logic [1:0]     i_offset,
  output rv32i_mem_wmask o_mask,
  output logic [31:0]    o_wdata,
  output logic           o_overflow
);

  // Seven bits wide so that a shift of up to 3 keeps every mask bit visible.
  logic [6:0] w_mask_wide;

  assign w_mask_wide = {3'b000, i_mask} << i_offset;
  assign o_mask      = w_mask_wide[3:0];
  assign o_overflow  = |w_mask_wide[6:4];
  assign o_wdata     = i_wdata << lane_shift(i_offset);

endmodule

// File: rtl/mem_align_bridge.sv
// Bridge between the multicycle rv32i memory port and a word-addressed
// physical memory. Accepts a held CPU request, steers it to the right byte
// lanes, runs one physical access and returns a single-cycle response.
// A saturating cycle counter aborts accesses that never complete.
//
//   state  | meaning
//   IDLE   | waiting for a CPU read or write request
//   ACCESS | physical strobe held, waiting for pmem_resp or timeout
//   RESP   | mem_resp asserted for this one cycle, strobes low
module mem_align_bridge
  import mem_align_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ABORT_DATA     = MEM_ABORT_DATA
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [31:0]    mem_address,
  input  logic           mem_read,
  input  logic           mem_write,
  input  rv32i_mem_wmask mem_byte_enable,
  input  logic [31:0]    mem_wdata,
  output logic           mem_resp,
  output logic [31:0]    mem_rdata,
  output logic [31:0]    pmem_address,
  output logic           pmem_read,
  output logic           pmem_write,
  output rv32i_mem_wmask pmem_wmask,
  output logic [31:0]    pmem_wdata,
  input  logic [31:0]    pmem_rdata,
  input  logic           pmem_resp,
  output logic           align_err,
  output logic           timeout_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  mem_bridge_state_t r_state;
  mem_bridge_state_t w_state_nxt;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic           r_mem_resp,     w_mem_resp_nxt;
  logic [31:0]    r_mem_rdata,    w_mem_rdata_nxt;
  logic [31:0]    r_pmem_address, w_pmem_address_nxt;
  logic           r_pmem_read,    w_pmem_read_nxt;
  logic           r_pmem_write,   w_pmem_write_nxt;
  rv32i_mem_wmask r_pmem_wmask,   w_pmem_wmask_nxt;
  logic [31:0]    r_pmem_wdata,   w_pmem_wdata_nxt;
  logic           r_align_err,    w_align_err_nxt;
  logic           r_timeout_err,  w_timeout_err_nxt;
  logic           r_rw_conflict,  w_rw_conflict_nxt;

  rv32i_mem_wmask w_lane_mask;
  logic [31:0]    w_lane_wdata;
  logic           w_lane_ovf;
  logic           w_timeout_hit;

  byte_lane_align u_lane (
    .i_mask     (mem_byte_enable),
    .i_wdata    (mem_wdata),
    .i_offset   (mem_address[1:0]),
    .o_mask     (w_lane_mask),
    .o_wdata    (w_lane_wdata),
    .o_overflow (w_lane_ovf)
  );

  // A zero timeout parameter removes the abort path entirely.
  assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_TERM);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_mem_resp_nxt     = 1'b0;
    w_align_err_nxt    = 1'b0;
    w_timeout_err_nxt  = 1'b0;
    w_mem_rdata_nxt    = r_mem_rdata;
    w_pmem_address_nxt = r_pmem_address;
    w_pmem_read_nxt    = r_pmem_read;
    w_pmem_write_nxt   = r_pmem_write;
    w_pmem_wmask_nxt   = r_pmem_wmask;
    w_pmem_wdata_nxt   = r_pmem_wdata;
    w_rw_conflict_nxt  = r_rw_conflict;

    unique case (r_state)
      IDLE: begin
        if (mem_read || mem_write) begin
          w_pmem_address_nxt = {mem_address[31:2], 2'b00};
          w_pmem_wmask_nxt   = w_lane_mask;
          w_pmem_wdata_nxt   = w_lane_wdata;
          w_cnt_nxt          = '0;
          w_rw_conflict_nxt  = mem_read && mem_write;
          if (w_lane_ovf) begin
            // Mask spills past lane 3: drop the access and answer at once.
            w_state_nxt      = RESP;
            w_mem_resp_nxt   = 1'b1;
            w_align_err_nxt  = 1'b1;
            w_mem_rdata_nxt  = '0;
            w_pmem_read_nxt  = 1'b0;
            w_pmem_write_nxt = 1'b0;
          end else begin
            // Simultaneous read and write resolves to a write.
            w_state_nxt      = ACCESS;
            w_pmem_write_nxt = mem_write;
            w_pmem_read_nxt  = mem_read && !mem_write;
          end
        end
      end

      ACCESS: begin
        w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
        if (pmem_resp) begin
          w_state_nxt      = RESP;
          w_mem_resp_nxt   = 1'b1;
          w_align_err_nxt  = r_rw_conflict;
          w_pmem_read_nxt  = 1'b0;
          w_pmem_write_nxt = 1'b0;
          if (r_pmem_read) begin
            w_mem_rdata_nxt = pmem_rdata;
          end
        end else if (w_timeout_hit) begin
          w_state_nxt       = RESP;
          w_mem_resp_nxt    = 1'b1;
          w_align_err_nxt   = r_rw_conflict;
          w_timeout_err_nxt = 1'b1;
          w_mem_rdata_nxt   = ABORT_DATA;
          w_pmem_read_nxt   = 1'b0;
          w_pmem_write_nxt  = 1'b0;
        end
      end

      RESP: begin
        // Any request still held by the CPU here is deliberately ignored.
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt      = IDLE;
        w_pmem_read_nxt  = 1'b0;
        w_pmem_write_nxt = 1'b0;
      end
    endcase
  end

  // Output, capture and timeout counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_mem_resp     <= 1'b0;
      r_mem_rdata    <= '0;
      r_pmem_address <= '0;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_wmask   <= '0;
      r_pmem_wdata   <= '0;
      r_align_err    <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_rw_conflict  <= 1'b0;
    end else begin
      r_cnt          <= w_cnt_nxt;
      r_mem_resp     <= w_mem_resp_nxt;
      r_mem_rdata    <= w_mem_rdata_nxt;
      r_pmem_address <= w_pmem_address_nxt;
      r_pmem_read    <= w_pmem_read_nxt;
      r_pmem_write   <= w_pmem_write_nxt;
      r_pmem_wmask   <= w_pmem_wmask_nxt;
      r_pmem_wdata   <= w_pmem_wdata_nxt;
      r_align_err    <= w_align_err_nxt;
      r_timeout_err  <= w_timeout_err_nxt;
      r_rw_conflict  <= w_rw_conflict_nxt;
    end
  end

  assign mem_resp     = r_mem_resp;
  assign mem_rdata    = r_mem_rdata;
  assign pmem_address = r_pmem_address;
  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_wmask   = r_pmem_wmask;
  assign pmem_wdata   = r_pmem_wdata;
  assign align_err    = r_align_err;
  assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_mem_align_bridge.sv
// Testbench for mem_align_bridge with a short timeout so that abort paths
// are reachable quickly.
module tb_mem_align_bridge;

  localparam int unsigned TO_CYC = 4;
  localparam logic [31:0] ABORT  = 32'hDEADBEEF;
  localparam int          NEVER  = 99;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  logic [31:0] pmem_address;
  logic        pmem_read;
  logic        pmem_write;
  logic [3:0]  pmem_wmask;
  logic [31:0] pmem_wdata;
  logic [31:0] pmem_rdata;
  logic        pmem_resp;
  logic        align_err;
  logic        timeout_err;

  always #5 clk = ~clk;

  mem_align_bridge #(.TIMEOUT_CYCLES(TO_CYC), .ABORT_DATA(ABORT)) dut (
    .clk(clk), .rst(rst),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wmask(pmem_wmask), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .align_err(align_err), .timeout_err(timeout_err)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] model_rdata;

  // Observations from the most recent access.
  int          ob_resp_c, ob_strobe_first, ob_strobe_cnt, ob_aerr_cnt, ob_terr_cnt;
  logic        ob_aerr_at_resp, ob_terr_at_resp, ob_overlap, ob_unstable, ob_post_bad;
  logic        ob_rd_seen, ob_wr_seen;
  logic [31:0] ob_rdata, ob_addr, ob_wdata;
  logic [3:0]  ob_mask;

  typedef struct {
    int          resp_c;
    logic        strobe;
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  mask;
    logic        aerr;
    logic        terr;
  } exp_t;

  // Reference behaviour from the access rules, using plain arithmetic.
  function automatic exp_t model(input logic [31:0] addr, input logic rd, input logic wr,
                                 input logic [3:0] be, input logic [31:0] wdata, input int k,
                                 input logic [31:0] memword, input logic [31:0] prev);
    exp_t e;
    int unsigned off;
    int unsigned m;
    longint unsigned w;
    off = addr % 4;
    m = be * (2 ** off);
    w = longint'(wdata) * (longint'(256) ** off);
    e.addr  = addr - off;
    e.mask  = 4'(m % 16);
    e.wdata = 32'(w % 64'h1_0000_0000);
    e.is_wr = wr;
    e.aerr  = rd && wr;
    e.terr  = 1'b0;
    if (m > 15) begin
      e.strobe = 1'b0; e.resp_c = 1; e.rdata = 32'h0; e.aerr = 1'b1;
    end else if (k >= int'(TO_CYC)) begin
      e.strobe = 1'b1; e.resp_c = TO_CYC + 1; e.rdata = ABORT; e.terr = 1'b1;
    end else begin
      e.strobe = 1'b1; e.resp_c = 2 + k; e.rdata = wr ? prev : memword;
    end
    return e;
  endfunction

  // Drives one CPU request and plays the physical memory, answering k cycles
  // after the strobe first appears (k >= NEVER: never answers).
  task automatic do_access(input logic [31:0] addr, input logic rd, input logic wr,
                           input logic [3:0] be, input logic [31:0] wdata, input int k,
                           input logic [31:0] memword, input logic hold);
    int c;
    logic done;
    ob_resp_c = 0; ob_strobe_first = 0; ob_strobe_cnt = 0; ob_aerr_cnt = 0; ob_terr_cnt = 0;
    ob_aerr_at_resp = 0; ob_terr_at_resp = 0; ob_overlap = 0; ob_unstable = 0; ob_post_bad = 0;
    ob_rd_seen = 0; ob_wr_seen = 0; ob_rdata = 0; ob_addr = 0; ob_wdata = 0; ob_mask = 0;
    mem_address = addr; mem_read = rd; mem_write = wr; mem_byte_enable = be; mem_wdata = wdata;
    c = 0; done = 0;
    while (!done && c < 40) begin
      @(posedge clk); #1; c++;
      pmem_resp = 1'b0;
      pmem_rdata = $urandom;
      if (pmem_read && pmem_write) ob_overlap = 1;
      if (pmem_read || pmem_write) begin
        ob_strobe_cnt++;
        if (ob_strobe_first == 0) begin
          ob_strobe_first = c; ob_addr = pmem_address; ob_mask = pmem_wmask;
          ob_wdata = pmem_wdata; ob_rd_seen = pmem_read; ob_wr_seen = pmem_write;
        end else if (pmem_address !== ob_addr || pmem_wmask !== ob_mask ||
                     pmem_wdata !== ob_wdata || pmem_read !== ob_rd_seen) begin
          ob_unstable = 1;
        end
      end
      if (align_err) ob_aerr_cnt++;
      if (timeout_err) ob_terr_cnt++;
      if (mem_resp) begin
        ob_resp_c = c; ob_rdata = mem_rdata;
        ob_aerr_at_resp = align_err; ob_terr_at_resp = timeout_err; done = 1;
      end else if (c == 1 + k) begin
        pmem_resp = 1'b1; pmem_rdata = memword;
      end
    end
    pmem_resp = 1'b0;
    if (!hold) begin mem_read = 0; mem_write = 0; end
    @(posedge clk); #1;
    if (mem_resp || pmem_read || pmem_write || align_err || timeout_err) ob_post_bad = 1;
    if (hold) begin
      mem_read = 0; mem_write = 0;
      @(posedge clk); #1;
      if (mem_resp || pmem_read || pmem_write) ob_post_bad = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mem_resp, pmem_read, pmem_write, align_err, timeout_err} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got=%b want=00000",
                         {mem_resp, pmem_read, pmem_write, align_err, timeout_err});
    end
    checks++;
    if (mem_rdata !== 32'h0 || pmem_address !== 32'h0 || pmem_wdata !== 32'h0 || pmem_wmask !== 4'h0) begin
      errors++; $display("FAIL reset_data rdata=%h addr=%h wdata=%h mask=%b want all 0",
                         mem_rdata, pmem_address, pmem_wdata, pmem_wmask);
    end
    rst = 1'b0;
    model_rdata = 32'h0;
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    do_access(32'h100, 1, 0, 4'b1111, 32'h0, 3, 32'h12345678, 0);
    checks++; if (ob_strobe_first !== 1 || !ob_rd_seen || ob_wr_seen) begin errors++;
      $display("FAIL lw_strobe first=%0d rd=%b wr=%b want 1/1/0", ob_strobe_first, ob_rd_seen, ob_wr_seen); end
    checks++; if (ob_addr !== 32'h100) begin errors++; $display("FAIL lw_addr got=%h want=00000100", ob_addr); end
    checks++; if (ob_resp_c !== 5) begin errors++; $display("FAIL lw_latency got=%0d want=5", ob_resp_c); end
    checks++; if (ob_rdata !== 32'h12345678) begin errors++; $display("FAIL lw_rdata got=%h want=12345678", ob_rdata); end
    checks++; if (ob_terr_cnt !== 0 || ob_post_bad) begin errors++;
      $display("FAIL lw_terminal_resp_wins terr=%0d post_bad=%b want 0/0", ob_terr_cnt, ob_post_bad); end
    model_rdata = 32'h12345678;
  endtask

  task automatic test_sb();
    do_access(32'h203, 0, 1, 4'b0001, 32'h000000AB, 1, 32'h55555555, 0);
    checks++; if (ob_addr !== 32'h200 || ob_mask !== 4'b1000) begin errors++;
      $display("FAIL sb_lane addr=%h mask=%b want 00000200/1000", ob_addr, ob_mask); end
    checks++; if (ob_wdata !== 32'hAB000000 || !ob_wr_seen || ob_rd_seen) begin errors++;
      $display("FAIL sb_wdata got=%h wr=%b rd=%b want AB000000/1/0", ob_wdata, ob_wr_seen, ob_rd_seen); end
    checks++; if (ob_resp_c !== 3 || ob_post_bad) begin errors++;
      $display("FAIL sb_resp cycle=%0d post_bad=%b want 3/0", ob_resp_c, ob_post_bad); end
    checks++; if (ob_rdata !== model_rdata) begin errors++;
      $display("FAIL sb_rdata_kept got=%h want=%h", ob_rdata, model_rdata); end
  endtask

  task automatic test_misaligned();
    do_access(32'h103, 1, 0, 4'b0011, 32'h0, 0, 32'h77777777, 0);
    checks++; if (ob_strobe_cnt !== 0) begin errors++; $display("FAIL sh_mis_strobe got=%0d want=0", ob_strobe_cnt); end
    checks++; if (ob_resp_c !== 1 || !ob_aerr_at_resp || ob_aerr_cnt !== 1) begin errors++;
      $display("FAIL sh_mis_err resp_c=%0d aerr_at_resp=%b aerr_cnt=%0d want 1/1/1",
               ob_resp_c, ob_aerr_at_resp, ob_aerr_cnt); end
    checks++; if (ob_rdata !== 32'h0) begin errors++; $display("FAIL sh_mis_rdata got=%h want=00000000", ob_rdata); end
    model_rdata = 32'h0;
  endtask

  task automatic test_timeout();
    do_access(32'h400, 1, 0, 4'b1111, 32'h0, NEVER, 32'h0, 0);
    checks++; if (ob_resp_c !== 5) begin errors++; $display("FAIL to_latency got=%0d want=5", ob_resp_c); end
    checks++; if (ob_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL to_rdata got=%h want=deadbeef", ob_rdata); end
    checks++; if (!ob_terr_at_resp || ob_terr_cnt !== 1 || ob_post_bad) begin errors++;
      $display("FAIL to_pulse at_resp=%b cnt=%0d post_bad=%b want 1/1/0", ob_terr_at_resp, ob_terr_cnt, ob_post_bad); end
    model_rdata = ABORT;
  endtask

  task automatic test_reset_in_access();
    mem_address = 32'h300; mem_read = 1; mem_write = 0; mem_byte_enable = 4'hF;
    @(posedge clk); #1;
    checks++; if (pmem_read !== 1'b1) begin errors++; $display("FAIL rst_acc_start got=%b want=1", pmem_read); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({mem_resp, pmem_read, pmem_write, align_err, timeout_err} !== 5'b0 || mem_rdata !== 32'h0 ||
        pmem_address !== 32'h0 || pmem_wmask !== 4'h0 || pmem_wdata !== 32'h0) begin
      errors++; $display("FAIL rst_acc_zero flags=%b rdata=%h addr=%h want all 0",
                         {mem_resp, pmem_read, pmem_write, align_err, timeout_err}, mem_rdata, pmem_address);
    end
    rst = 1'b0; mem_read = 0;
    model_rdata = 32'h0;
    @(posedge clk); #1;
    checks++; if (pmem_read !== 1'b0 || mem_resp !== 1'b0) begin errors++;
      $display("FAIL rst_acc_idle strobe=%b resp=%b want 0/0", pmem_read, mem_resp); end
    do_access(32'h304, 1, 0, 4'hF, 32'h0, 1, 32'hCAFEF00D, 0);
    checks++; if (ob_resp_c !== 3 || ob_rdata !== 32'hCAFEF00D || ob_addr !== 32'h304) begin errors++;
      $display("FAIL rst_acc_lw resp_c=%0d rdata=%h addr=%h want 3/cafef00d/00000304", ob_resp_c, ob_rdata, ob_addr); end
    model_rdata = 32'hCAFEF00D;
  endtask

  task automatic test_back_to_back();
    int r1, s1;
    do_access(32'h10, 0, 1, 4'hF, 32'h01020304, 0, 32'h0, 0);
    r1 = ob_resp_c; s1 = ob_strobe_cnt;
    checks++; if (ob_addr !== 32'h10 || ob_wdata !== 32'h01020304 || r1 !== 2 || s1 !== 1 || ob_overlap) begin
      errors++; $display("FAIL b2b_sw addr=%h wdata=%h resp_c=%0d strobes=%0d ovl=%b want 10/01020304/2/1/0",
                         ob_addr, ob_wdata, r1, s1, ob_overlap); end
    do_access(32'h14, 1, 0, 4'hF, 32'h0, 0, 32'h89ABCDEF, 0);
    checks++; if (ob_addr !== 32'h14 || !ob_rd_seen || ob_wr_seen || ob_resp_c !== 2 ||
                  ob_rdata !== 32'h89ABCDEF || ob_overlap || ob_post_bad) begin
      errors++; $display("FAIL b2b_lw addr=%h rd=%b wr=%b resp_c=%0d rdata=%h want 14/1/0/2/89abcdef",
                         ob_addr, ob_rd_seen, ob_wr_seen, ob_resp_c, ob_rdata); end
    model_rdata = 32'h89ABCDEF;
  endtask

  task automatic test_hold_in_resp();
    do_access(32'h500, 1, 0, 4'hF, 32'h0, 0, 32'h0BADCAFE, 1);
    checks++; if (ob_resp_c !== 2 || ob_rdata !== 32'h0BADCAFE || ob_post_bad || ob_strobe_cnt !== 1) begin
      errors++; $display("FAIL hold_resp resp_c=%0d rdata=%h post_bad=%b strobes=%0d want 2/0badcafe/0/1",
                         ob_resp_c, ob_rdata, ob_post_bad, ob_strobe_cnt); end
    model_rdata = 32'h0BADCAFE;
    do_access(32'h600, 1, 1, 4'b0011, 32'h0000BEEF, 0, 32'h11111111, 0);
    checks++; if (!ob_wr_seen || ob_rd_seen || ob_aerr_cnt !== 1 || !ob_aerr_at_resp ||
                  ob_wdata !== 32'h0000BEEF || ob_rdata !== model_rdata) begin
      errors++; $display("FAIL rdwr_conflict wr=%b rd=%b aerr=%0d wdata=%h rdata=%h want 1/0/1/0000beef/%h",
                         ob_wr_seen, ob_rd_seen, ob_aerr_cnt, ob_wdata, ob_rdata, model_rdata); end
  endtask

  task automatic test_random();
    exp_t e;
    logic [31:0] addr, wdata, memword;
    logic rd, wr;
    logic [3:0] be;
    int k, sel;
    for (int i = 0; i < 40; i++) begin
      addr = $urandom; wdata = $urandom; memword = $urandom;
      sel = $urandom_range(0, 3);
      rd = sel[0]; wr = sel[1];
      if (!rd && !wr) rd = 1;
      case ($urandom_range(0, 3))
        0: be = 4'b0001;
        1: be = 4'b0011;
        2: be = 4'b1111;
        default: be = 4'($urandom);
      endcase
      if (be == 4'b0) be = 4'b0100;
      k = $urandom_range(0, 5);
      e = model(addr, rd, wr, be, wdata, k, memword, model_rdata);
      do_access(addr, rd, wr, be, wdata, k, memword, 0);
      checks++;
      if (ob_resp_c !== e.resp_c || ob_rdata !== e.rdata || ob_aerr_cnt !== int'(e.aerr) ||
          ob_terr_cnt !== int'(e.terr) || ob_post_bad || ob_overlap || ob_unstable) begin
        errors++; $display("FAIL rnd%0d_resp c=%0d rdata=%h aerr=%0d terr=%0d bad=%b%b%b want c=%0d rdata=%h aerr=%b terr=%b",
                           i, ob_resp_c, ob_rdata, ob_aerr_cnt, ob_terr_cnt, ob_post_bad, ob_overlap, ob_unstable,
                           e.resp_c, e.rdata, e.aerr, e.terr);
      end
      checks++;
      if (e.strobe) begin
        if (ob_strobe_first !== 1 || ob_strobe_cnt !== e.resp_c - 1 || ob_addr !== e.addr ||
            ob_mask !== e.mask || ob_wdata !== e.wdata || ob_wr_seen !== e.is_wr || ob_rd_seen === e.is_wr) begin
          errors++; $display("FAIL rnd%0d_pmem first=%0d n=%0d addr=%h mask=%b wdata=%h wr=%b want 1/%0d/%h/%b/%h/%b",
                             i, ob_strobe_first, ob_strobe_cnt, ob_addr, ob_mask, ob_wdata, ob_wr_seen,
                             e.resp_c - 1, e.addr, e.mask, e.wdata, e.is_wr);
        end
      end else if (ob_strobe_cnt !== 0) begin
        errors++; $display("FAIL rnd%0d_drop strobes=%0d want=0", i, ob_strobe_cnt);
      end
      model_rdata = e.rdata;
    end
  endtask

  initial begin
    rst = 1'b1; mem_address = 0; mem_read = 0; mem_write = 0; mem_byte_enable = 0; mem_wdata = 0;
    pmem_rdata = 0; pmem_resp = 0; model_rdata = 0;
    test_reset();
    test_lw();
    test_sb();
    test_misaligned();
    test_timeout();
    test_reset_in_access();
    test_back_to_back();
    test_hold_in_resp();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
